// File: rtl/ab_pkg.sv
// ab_pkg: default sizing for the A/B memory datapath
package ab_pkg;
  localparam int DW      = 8;
  localparam int DEPTH_A = 8;
  localparam int DEPTH_B = 4;
  localparam int AW      = $clog2(DEPTH_A);
  localparam int BW      = $clog2(DEPTH_B);
endpackage

// File: rtl/ab_mem_datapath_wrap_counter.sv
// wrap_counter: enable-driven modulo-N counter with sync active-low reset
module wrap_counter #(
  parameter int N = 8,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);
  localparam logic [W-1:0] LAST = W'(N - 1);
  always_ff @(posedge clk)
    if (!rst) count <= '0;
    else if (en) count <= (count == LAST) ? '0 : count + 1'b1;
endmodule

// File: rtl/ab_mem_datapath.sv
// ab_mem_datapath: serial-load memory A, pairwise max into memory B
module ab_mem_datapath #(
  parameter int DW      = ab_pkg::DW,
  parameter int DEPTH_A = ab_pkg::DEPTH_A,
  parameter int DEPTH_B = ab_pkg::DEPTH_B,
  parameter int AW      = $clog2(DEPTH_A),
  parameter int BW      = $clog2(DEPTH_B)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          WEA,
  input  logic          IncA,
  input  logic          WEB,
  input  logic          IncB,
  input  logic [DW-1:0] data_in,
  input  logic [BW-1:0] rd_addr_b,
  output logic [DW-1:0] rd_data_b,
  output logic [AW-1:0] addr_a,
  output logic [BW-1:0] addr_b,
  output logic [DW-1:0] pair_max,
  output logic [BW:0]   b_count,
  output logic          b_full
);
  localparam logic [BW:0] B_MAX = (BW+1)'(DEPTH_B);
  logic [DW-1:0] mem_a [DEPTH_A];
  logic [DW-1:0] mem_b [DEPTH_B];
  logic [DW-1:0] r_cur, r_prev;
  logic [BW:0]   b_count_nxt;
  wrap_counter #(.N(DEPTH_A), .W(AW)) u_cnt_a (.clk(clk), .rst(rst), .en(IncA), .count(addr_a));
  wrap_counter #(.N(DEPTH_B), .W(BW)) u_cnt_b (.clk(clk), .rst(rst), .en(IncB), .count(addr_b));
  assign pair_max    = (r_cur >= r_prev) ? r_cur : r_prev;
  assign rd_data_b   = mem_b[rd_addr_b];
  assign b_count_nxt = (WEB && b_count < B_MAX) ? b_count + 1'b1 : b_count;
  // memories are never cleared; only the strobes are gated by reset
  always_ff @(posedge clk) begin
    if (rst && WEA) mem_a[addr_a] <= data_in;
    if (rst && WEB) mem_b[addr_b] <= pair_max;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cur   <= '0;
      r_prev  <= '0;
      b_count <= '0;
      b_full  <= 1'b0;
    end else begin
      if (!WEA) begin
        r_cur  <= mem_a[addr_a];
        r_prev <= r_cur;
      end
      b_count <= b_count_nxt;
      b_full  <= (b_count_nxt == B_MAX);
    end
  end
endmodule

// File: tb/tb_ab_mem_datapath.sv
// tb_ab_mem_datapath: directed stimulus with a reference-model scoreboard
module tb_ab_mem_datapath;
  logic       clk = 0;
  logic       rst = 0;
  logic       WEA = 0, IncA = 0, WEB = 0, IncB = 0;
  logic [7:0] data_in = 0;
  logic [1:0] rd_addr_b = 0;
  logic [7:0] rd_data_b, pair_max;
  logic [2:0] addr_a, b_count;
  logic [1:0] addr_b;
  logic       b_full;
  int tests = 0, fails = 0;
  typedef struct {
    logic [2:0] aa;
    logic [1:0] ab;
    logic [7:0] pm;
    logic [2:0] bc;
    logic       bf;
  } exp_t;
  exp_t exp_q[$];
  logic [7:0] m_a [8];
  logic [7:0] m_b [4];
  logic [7:0] m_cur = 0, m_prev = 0;
  logic [2:0] m_aa = 0, m_bc = 0;
  logic [1:0] m_ab = 0;
  logic       m_bf = 0;
  ab_mem_datapath dut (
    .clk(clk), .rst(rst), .WEA(WEA), .IncA(IncA), .WEB(WEB), .IncB(IncB),
    .data_in(data_in), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
    .addr_a(addr_a), .addr_b(addr_b), .pair_max(pair_max),
    .b_count(b_count), .b_full(b_full)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask
  task automatic step(input logic r, input logic wa, input logic ia, input logic wb, input logic ib, input logic [7:0] d);
    logic [7:0] pm, rd;
    exp_t e, g;
    rst = r; WEA = wa; IncA = ia; WEB = wb; IncB = ib; data_in = d;
    if (!r) begin
      m_aa = 0; m_ab = 0; m_cur = 0; m_prev = 0; m_bc = 0; m_bf = 0;
    end else begin
      pm = (m_cur >= m_prev) ? m_cur : m_prev;
      rd = m_a[m_aa];
      if (wa) m_a[m_aa] = d;
      else begin m_prev = m_cur; m_cur = rd; end
      if (wb) begin m_b[m_ab] = pm; if (m_bc < 4) m_bc++; end
      m_bf = (m_bc == 4);
      if (ia) m_aa = (m_aa == 7) ? 3'd0 : m_aa + 3'd1;
      if (ib) m_ab = (m_ab == 3) ? 2'd0 : m_ab + 2'd1;
    end
    e.aa = m_aa; e.ab = m_ab; e.pm = (m_cur >= m_prev) ? m_cur : m_prev; e.bc = m_bc; e.bf = m_bf;
    exp_q.push_back(e);
    @(posedge clk); #1;
    g = exp_q.pop_front();
    chk("addr_a", addr_a, g.aa);
    chk("addr_b", addr_b, g.ab);
    chk("pair_max", pair_max, g.pm);
    chk("b_count", b_count, g.bc);
    chk("b_full", b_full, g.bf);
  endtask
  task automatic rd_b(input int a, input logic [7:0] e);
    rd_addr_b = 2'(a); #1;
    chk($sformatf("rd_data_b[%0d]", a), rd_data_b, e);
  endtask
  initial begin
    logic [7:0] load [8] = '{10, 3, 7, 7, 200, 1, 0, 255};
    logic [7:0] gold [4] = '{10, 7, 200, 255};
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 8'h55);
    chk("reset addr_a", addr_a, 0);
    chk("reset pair_max", pair_max, 0);
    for (int i = 0; i < 8; i++) step(1, 1, 1, 0, 0, load[i]);
    chk("load wrap addr_a", addr_a, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 1, 1, 0);
      step(1, 0, 1, 0, 0, 0);
    end
    chk("unsigned pair_max", pair_max, 255);
    step(1, 0, 0, 1, 1, 0);
    chk("b_full after 4th", b_full, 1);
    for (int i = 0; i < 4; i++) rd_b(i, gold[i]);
    step(1, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 1, 0);
    chk("b_count saturated", b_count, 4);
    rd_b(0, m_b[0]);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 0);
    chk("addr_b wrap", addr_b, 0);
    step(1, 0, 1, 0, 0, 0);
    step(1, 1, 1, 1, 1, 8'd99);
    rd_b(0, m_b[0]);
    rd_b(1, m_b[1]);
    for (int i = 0; i < 8; i++) step(1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 8'd11);
    step(1, 1, 1, 0, 0, 8'd22);
    step(1, 1, 1, 0, 0, 8'd33);
    step(0, 1, 1, 1, 1, 8'd44);
    chk("midload addr_a", addr_a, 0);
    chk("midload b_count", b_count, 0);
    step(1, 0, 1, 0, 0, 0);
    chk("retained memA0", pair_max, 11);
    step(1, 0, 1, 0, 0, 0);
    chk("retained memA1", pair_max, 22);
    step(1, 0, 1, 0, 0, 0);
    chk("retained memA2", pair_max, 33);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
